// File: rtl/full_adder_using2halfadders.sv
// Registered WIDTH-bit ripple-carry adder; each bit is a full adder built from two half-adder cells.
// Optional macro FA_OVF_EN adds the registered signed-overflow output ovf.
module full_adder_using2halfadders #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
`ifdef FA_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Half-adder cell: {carry, sum} of two bits.
  function automatic logic [1:0] half_adder(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  logic [WIDTH:0]   cin_s;
  logic [WIDTH-1:0] s1_s;
  logic [WIDTH-1:0] c1_s;
  logic [WIDTH-1:0] c2_s;
  logic [WIDTH-1:0] rsum_s;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_d;
  logic             carry_q;
  logic             out_valid_d;
  logic             out_valid_q;
`ifdef FA_OVF_EN
  logic             ovf_d;
  logic             ovf_q;
`endif

  assign cin_s[0] = Cin;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    assign {c1_s[i], s1_s[i]}   = half_adder(a[i], b[i]);
    assign {c2_s[i], rsum_s[i]} = half_adder(s1_s[i], cin_s[i]);
    assign cin_s[i+1]           = c1_s[i] | c2_s[i];
  end

  // Next-state: load the ripple result on an accepted input, otherwise hold.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
`ifdef FA_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      sum_d       = rsum_s;
      carry_d     = cin_s[WIDTH];
      out_valid_d = 1'b1;
`ifdef FA_OVF_EN
      ovf_d       = cin_s[WIDTH-1] ^ cin_s[WIDTH];
`endif
    end else begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      out_valid_d = 1'b0;
`ifdef FA_OVF_EN
      ovf_d       = ovf_q;
`endif
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef FA_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
`ifdef FA_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;
`ifdef FA_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_using2halfadders.sv
// Self-checking bench: WIDTH=1 exhaustive, WIDTH=4 directed/hold/reset, WIDTH=8 random vs arithmetic model.
module tb_full_adder_using2halfadders;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a1, b1, cin1, v1, sum1, carry1, ov1;
  logic [3:0] a4, b4, sum4;
  logic       cin4, v4, carry4, ov4;
  logic [7:0] a8, b8, sum8;
  logic       cin8, v8, carry8, ov8;
`ifdef FA_OVF_EN
  logic       ovf1, ovf4, ovf8;
`endif

  full_adder_using2halfadders #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .Cin(cin1), .in_valid(v1),
    .sum(sum1), .carry(carry1), .out_valid(ov1)
`ifdef FA_OVF_EN
    , .ovf(ovf1)
`endif
  );

  full_adder_using2halfadders #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .Cin(cin4), .in_valid(v4),
    .sum(sum4), .carry(carry4), .out_valid(ov4)
`ifdef FA_OVF_EN
    , .ovf(ovf4)
`endif
  );

  full_adder_using2halfadders #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .Cin(cin8), .in_valid(v8),
    .sum(sum8), .carry(carry8), .out_valid(ov8)
`ifdef FA_OVF_EN
    , .ovf(ovf8)
`endif
  );

  int tests = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed overflow of a W-bit two's-complement add: true result outside [-2^(W-1), 2^(W-1)-1].
  function automatic logic ovf_model(input int w, input logic [63:0] x, input logic [63:0] y, input logic c);
    longint sx, sy, r, lo, hi;
    sx = (x[w-1]) ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy = (y[w-1]) ? longint'(y) - (longint'(1) << w) : longint'(y);
    r  = sx + sy + longint'(c);
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    return (r < lo) || (r > hi);
  endfunction

  initial begin
    int         exp_i;
    logic [4:0] exp4;
    logic [8:0] exp8;

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; v4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; v8 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_sum1", {carry1, sum1}, 64'd0);
    chk("rst_ov1", ov1, 64'd0);
    chk("rst_sum4", {carry4, sum4}, 64'd0);
    chk("rst_ov4", ov4, 64'd0);
    chk("rst_sum8", {carry8, sum8}, 64'd0);
    chk("rst_ov8", ov8, 64'd0);
`ifdef FA_OVF_EN
    chk("rst_ovf", {ovf1, ovf4, ovf8}, 64'd0);
`endif

    // WIDTH=1 exhaustive, accepted on the same edge reset is released
    rst_n = 1'b1;
    for (int v = 0; v < 8; v++) begin
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; v1 = 1'b1;
      exp_i = int'(v[2]) + int'(v[1]) + int'(v[0]);
      @(negedge clk);
      chk($sformatf("w1_sum_%0d", v), {carry1, sum1}, 64'(exp_i));
      chk($sformatf("w1_ov_%0d", v), ov1, 64'd1);
`ifdef FA_OVF_EN
      chk($sformatf("w1_ovf_%0d", v), ovf1, 64'(ovf_model(1, 64'(v[2]), 64'(v[1]), v[0])));
`endif
    end
    v1 = 1'b0;
    @(negedge clk);
    chk("w1_ov_idle", ov1, 64'd0);

    // WIDTH=4 directed
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; v4 = 1'b1;
    @(negedge clk);
    chk("w4_wrap", {carry4, sum4}, 64'h10);
    chk("w4_wrap_ov", ov4, 64'd1);
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0;
    @(negedge clk);
    chk("w4_7p8", {carry4, sum4}, 64'h0F);
`ifdef FA_OVF_EN
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    @(negedge clk);
    chk("w4_ovf_pos", {ovf4, carry4, sum4}, 64'h28);
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
    @(negedge clk);
    chk("w4_ovf_neg", {ovf4, carry4, sum4}, 64'h10);
`endif

    // Hold: load 3+4, then idle with changing inputs
    a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0;
    @(negedge clk);
    chk("w4_load7", {carry4, sum4}, 64'h07);
    v4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      @(negedge clk);
      chk($sformatf("w4_hold_%0d", k), {carry4, sum4}, 64'h07);
      chk($sformatf("w4_hold_ov_%0d", k), ov4, 64'd0);
    end

    // Reset overrides a simultaneous valid, then first result on release edge
    rst_n = 1'b0; v4 = 1'b1; a4 = 4'h5; b4 = 4'h0; cin4 = 1'b0;
    @(negedge clk);
    chk("w4_rst_sum", {carry4, sum4}, 64'd0);
    chk("w4_rst_ov", ov4, 64'd0);
    rst_n = 1'b1; a4 = 4'h1; b4 = 4'h1; cin4 = 1'b0; v4 = 1'b1;
    @(negedge clk);
    chk("w4_post_rst", {carry4, sum4}, 64'h02);
    chk("w4_post_rst_ov", ov4, 64'd1);
    v4 = 1'b0;
    @(negedge clk);
    chk("w4_post_rst_idle", ov4, 64'd0);

    // WIDTH=8 random back-to-back
    for (int n = 0; n < 1000; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); v8 = 1'b1;
      exp8 = 9'(int'(a8) + int'(b8) + int'(cin8));
      @(negedge clk);
      chk($sformatf("w8_sum_%0d", n), {carry8, sum8}, 64'(exp8));
      chk($sformatf("w8_ov_%0d", n), ov8, 64'd1);
`ifdef FA_OVF_EN
      chk($sformatf("w8_ovf_%0d", n), ovf8, 64'(ovf_model(8, 64'(a8), 64'(b8), cin8)));
`endif
    end
    v8 = 1'b0;
    @(negedge clk);
    chk("w8_ov_idle", ov8, 64'd0);
    chk("w8_hold", {carry8, sum8}, 64'(exp8));

    // Mid-stream reset discards the pending result on the wide instance
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; v8 = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("w8_mid_rst", {ov8, carry8, sum8}, 64'd0);
    rst_n = 1'b1; v8 = 1'b0;
    exp4 = 5'd0;
    @(negedge clk);
    chk("w8_after_rst", {ov8, carry8, sum8}, 64'(exp4));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/full_adder_using2halfadders.md
# full_adder_using2halfadders

Registered, width-parameterized binary adder built strictly from half-adder cells: each bit is a full adder made of two half adders, and the bits are chained as a ripple-carry adder. The default configuration (WIDTH=1) is the single-bit full adder used as the basic arithmetic leaf in datapaths. Results are captured in output registers one clock after a valid input, giving downstream logic a clean, glitch-free sum and carry.

## Interface
- WIDTH, 1, operand width in bits; legal range 1..64.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous, active-low reset.
- a  input  WIDTH  operand A, unsigned (two's complement when overflow feature used).
- b  input  WIDTH  operand B.
- Cin  input  1  carry-in to bit 0.
- in_valid  input  1  qualifies a, b, Cin for capture this cycle.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry-out of MSB.
- out_valid  output  1  high for one cycle per accepted input.
- ovf  output  1  registered signed overflow; present only with FA_OVF_EN.

## Operation
- Half adder cell: s = x XOR y, c = x AND y.
- Per-bit full adder i: HA1 on (a[i], b[i]) -> s1, c1; HA2 on (s1, cin_i) -> sum_i, c2; cout_i = c1 OR c2.
- cin_0 = Cin; cin_(i+1) = cout_i; carry = cout_(WIDTH-1).
- Arithmetic: {carry, sum} = a + b + Cin, exact, WIDTH+1 bits, no truncation or saturation.
- All-ones + 0 + Cin=1 wraps sum to 0 with carry=1.
- Ripple logic is purely combinational; only outputs are registered.
- Per-bit logic uses only the two half-adder instances and one OR; no behavioral "+" operator.

## Timing
- On rising clk with rst_n=0: sum=0, carry=0, out_valid=0, ovf=0 (if present). Reset overrides in_valid in the same cycle.
- On rising clk with rst_n=1 and in_valid=1: sum/carry/ovf load the combinational result of the current inputs; out_valid=1.
- On rising clk with rst_n=1 and in_valid=0: sum/carry/ovf hold previous values; out_valid=0.
- Latency: exactly 1 cycle from input capture to out_valid; throughput 1 result per cycle, back-to-back valids allowed, no backpressure.
- Reset release: first result may be accepted in the same edge where rst_n is first seen high.
- Reset asserted mid-stream discards the pending result; out_valid is 0 on the following cycle.
- Inputs must be stable at the clock edge only; no combinational input-to-output path.

## Configuration
- Macro FA_OVF_EN.
- Defined: ovf port exists; ovf register loads cin_(WIDTH-1) XOR carry-out on accepted input; reset 0; holds when in_valid=0.
- Undefined: ovf port and its register are absent; all other behavior identical.

## Test plan
- WIDTH=1, exhaustive: apply all 8 (a,b,Cin) from 000 to 111 with in_valid=1 -> next cycle (carry,sum) = 00,01,01,10,01,10,10,11; out_valid=1 each cycle.
- WIDTH=4: a=4'hF, b=4'h0, Cin=1 -> sum=4'h0, carry=1; a=4'h7, b=4'h8, Cin=0 -> sum=4'hF, carry=0.
- Hold: load a=4'h3, b=4'h4, Cin=0 (sum=7), then in_valid=0 with changing inputs for 3 cycles -> sum stays 7, carry 0, out_valid 0.
- Reset: rst_n=0 together with in_valid=1, a=4'h5 -> next cycle sum=0, carry=0, out_valid=0; deassert rst_n, apply a=4'h1, b=4'h1 -> sum=2 one cycle later.
- FA_OVF_EN, WIDTH=4: a=4'h7, b=4'h1, Cin=0 -> sum=4'h8, carry=0, ovf=1; a=4'hF, b=4'h1 -> sum=0, carry=1, ovf=0.
- Random: 1000 back-to-back valid vectors, WIDTH=8 -> each result equals a+b+Cin one cycle later.
